// File: rtl/rxc_translation_layer.sv
// RC (AXI-Stream requester completion) to RXC packet interface translation.
// Two registered skid stages (the input one optional) with a framing FSM
// between them that derives start/end flags, end offset and packet error.

`ifndef SIG_RC_TUSER_W
`define SIG_RC_TUSER_W 85
`endif

// Two-entry skid register: in_ready_o depends only on registered state.
module rxc_skid_reg #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         srst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);

  logic         out_valid_q, out_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] skid_data_q, skid_data_d;

  // Accept whenever the spill slot is free; the main register may still be
  // stalled, in which case the new beat parks in the spill slot.
  assign in_ready_o  = ~skid_valid_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

  // Next-state: refill the output from the spill slot first, then from input.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_ready_i || !out_valid_q) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_valid_i;
        if (in_valid_i) begin
          out_data_d = in_data_i;
        end
      end
    end else if (in_valid_i && !skid_valid_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data_i;
    end
  end

  // State registers; reset empties both entries and zeroes the data.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

module rxc_translation_layer #(
  parameter int C_PCI_DATA_WIDTH = 128,
  parameter int C_PIPELINE_INPUT = 1,
  parameter int C_DISC_BIT       = 42,
  parameter int C_SOF_BIT        = 32
) (
  input  logic                          CLK,
  input  logic                          RST_IN,
  input  logic                          M_AXIS_RC_TVALID,
  output logic                          M_AXIS_RC_TREADY,
  input  logic                          M_AXIS_RC_TLAST,
  input  logic [C_PCI_DATA_WIDTH-1:0]   M_AXIS_RC_TDATA,
  input  logic [C_PCI_DATA_WIDTH/32-1:0] M_AXIS_RC_TKEEP,
  input  logic [`SIG_RC_TUSER_W-1:0]    M_AXIS_RC_TUSER,
  input  logic                          RXC_DATA_READY,
  output logic                          RXC_DATA_VALID,
  output logic [C_PCI_DATA_WIDTH-1:0]   RXC_DATA,
  output logic                          RXC_DATA_START_FLAG,
  output logic [((C_PCI_DATA_WIDTH/32) <= 2 ? 1 : $clog2(C_PCI_DATA_WIDTH/32))-1:0] RXC_DATA_START_OFFSET,
  output logic                          RXC_DATA_END_FLAG,
  output logic [((C_PCI_DATA_WIDTH/32) <= 2 ? 1 : $clog2(C_PCI_DATA_WIDTH/32))-1:0] RXC_DATA_END_OFFSET,
  output logic                          RXC_DATA_ERROR
);

  localparam int C_DW     = C_PCI_DATA_WIDTH;
  localparam int C_KEEP_W = C_PCI_DATA_WIDTH / 32;
  localparam int C_OFF_W  = (C_KEEP_W <= 2) ? 1 : $clog2(C_KEEP_W);
  // Stage 1 carries data, keep, last, and the two TUSER bits we inspect.
  localparam int C_S1_W   = C_DW + C_KEEP_W + 1 + 2;
  // Stage 2 carries data, start, end offset, end, error.
  localparam int C_S2_W   = C_DW + 1 + C_OFF_W + 1 + 1;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_INPKT = 1'b1;

  logic                rst_done_q;
  logic                in_valid_gated;
  logic                s1_in_ready;
  logic                s2_in_ready;
  logic                f_valid;
  logic [C_S1_W-1:0]   s1_in_payload;
  logic [C_S1_W-1:0]   f_payload;
  logic [C_DW-1:0]     f_data;
  logic [C_KEEP_W-1:0] f_keep;
  logic [C_KEEP_W-1:0] f_keep_inc;
  logic                f_last;
  logic                f_disc;
  logic                f_sof;
  logic                f_fire;
  logic                f_start;
  logic                f_keep_contig;
  logic                f_beat_err;
  logic                f_sticky_eff;
  logic                f_err_out;
  logic [C_OFF_W-1:0]  f_end_off;
  logic [0:0]          state_q, state_d;
  logic                sticky_q, sticky_d;
  logic [C_S2_W-1:0]   s2_in_payload;
  logic [C_S2_W-1:0]   s2_out_payload;
  logic                unused_tuser;

  // Only the discontinue and SOF bits matter here; the rest is ignored.
  assign unused_tuser = ^M_AXIS_RC_TUSER;

  // Holds TREADY low during reset and for the first cycle after it.
  always_ff @(posedge CLK) begin
    if (RST_IN) begin
      rst_done_q <= 1'b0;
    end else begin
      rst_done_q <= 1'b1;
    end
  end

  assign in_valid_gated   = M_AXIS_RC_TVALID & rst_done_q;
  assign M_AXIS_RC_TREADY = rst_done_q & s1_in_ready;
  assign s1_in_payload    = {M_AXIS_RC_TDATA, M_AXIS_RC_TKEEP, M_AXIS_RC_TLAST,
                             M_AXIS_RC_TUSER[C_DISC_BIT], M_AXIS_RC_TUSER[C_SOF_BIT]};

  generate
    if (C_PIPELINE_INPUT != 0) begin : g_in_stage
      rxc_skid_reg #(.W(C_S1_W)) u_in_stage (
        .clk_i       (CLK),
        .srst_i      (RST_IN),
        .in_valid_i  (in_valid_gated),
        .in_ready_o  (s1_in_ready),
        .in_data_i   (s1_in_payload),
        .out_valid_o (f_valid),
        .out_data_o  (f_payload),
        .out_ready_i (s2_in_ready)
      );
    end else begin : g_in_wires
      assign s1_in_ready = s2_in_ready;
      assign f_valid     = in_valid_gated;
      assign f_payload   = s1_in_payload;
    end
  endgenerate

  // Framing works on beats as they move into the output stage; order is
  // preserved, so this is equivalent to advancing on accepted input beats.
  assign f_data  = f_payload[C_S1_W-1 -: C_DW];
  assign f_keep  = f_payload[3 +: C_KEEP_W];
  assign f_last  = f_payload[2];
  assign f_disc  = f_payload[1];
  assign f_sof   = f_payload[0];
  assign f_fire  = f_valid & s2_in_ready;
  assign f_start = (state_q == ST_IDLE);

  // keep & (keep+1) is zero exactly when keep has the form 0..01..1.
  assign f_keep_inc    = f_keep + C_KEEP_W'(1);
  assign f_keep_contig = ((f_keep & f_keep_inc) == '0);

  // Highest enabled dword of the beat.
  always_comb begin
    f_end_off = '0;
    for (int i = 0; i < C_KEEP_W; i++) begin
      if (f_keep[i]) begin
        f_end_off = C_OFF_W'(i);
      end
    end
  end

  assign f_beat_err   = f_disc
                      | (f_sof != f_start)
                      | (f_keep == '0)
                      | (f_last ? ~f_keep_contig : ~(&f_keep));
  // A start beat discards whatever error history a prior packet left.
  assign f_sticky_eff = f_start ? 1'b0 : sticky_q;
  assign f_err_out    = f_last & (f_sticky_eff | f_beat_err);

  // Next-state for the framing FSM and the per-packet sticky error.
  always_comb begin
    state_d  = state_q;
    sticky_d = sticky_q;
    if (f_fire) begin
      state_d  = f_last ? ST_IDLE : ST_INPKT;
      sticky_d = f_last ? 1'b0 : (f_sticky_eff | f_beat_err);
    end
  end

  // Framing FSM and sticky error registers.
  always_ff @(posedge CLK) begin
    if (RST_IN) begin
      state_q  <= ST_IDLE;
      sticky_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sticky_q <= sticky_d;
    end
  end

  assign s2_in_payload = {f_data, f_start, (f_last ? f_end_off : {C_OFF_W{1'b0}}),
                          f_last, f_err_out};

  rxc_skid_reg #(.W(C_S2_W)) u_out_stage (
    .clk_i       (CLK),
    .srst_i      (RST_IN),
    .in_valid_i  (f_valid),
    .in_ready_o  (s2_in_ready),
    .in_data_i   (s2_in_payload),
    .out_valid_o (RXC_DATA_VALID),
    .out_data_o  (s2_out_payload),
    .out_ready_i (RXC_DATA_READY)
  );

  assign RXC_DATA              = s2_out_payload[C_S2_W-1 -: C_DW];
  assign RXC_DATA_START_FLAG   = s2_out_payload[C_OFF_W + 2];
  assign RXC_DATA_END_OFFSET   = s2_out_payload[2 +: C_OFF_W];
  assign RXC_DATA_END_FLAG     = s2_out_payload[1];
  assign RXC_DATA_ERROR        = s2_out_payload[0];
  // Dword-aligned completions always start at dword 0.
  assign RXC_DATA_START_OFFSET = '0;

endmodule

// File: tb/tb_rxc_translation_layer.sv
// Directed bench for rxc_translation_layer (128-bit, input stage present).

`ifndef SIG_RC_TUSER_W
`define SIG_RC_TUSER_W 85
`endif

module tb_rxc_translation_layer;

  localparam int DW = 128;
  localparam int KW = 4;
  localparam int OW = 2;
  localparam int UW = `SIG_RC_TUSER_W;

  logic          CLK = 1'b0;
  logic          RST_IN = 1'b1;
  logic          tvalid = 1'b0;
  logic          tready;
  logic          tlast = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic [KW-1:0] tkeep = '0;
  logic [UW-1:0] tuser = '0;
  logic          rxready = 1'b1;
  logic          rxvalid;
  logic [DW-1:0] rxdata;
  logic          rxsf;
  logic [OW-1:0] rxso;
  logic          rxef;
  logic [OW-1:0] rxeo;
  logic          rxerr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  bit rand_done = 1'b0;

  typedef struct {
    logic [DW-1:0] d;
    logic          sf;
    logic [OW-1:0] so;
    logic          ef;
    logic [OW-1:0] eo;
    logic          err;
    int            cyc;
  } out_t;
  out_t outq[$];

  rxc_translation_layer #(
    .C_PCI_DATA_WIDTH (DW),
    .C_PIPELINE_INPUT (1),
    .C_DISC_BIT       (42),
    .C_SOF_BIT        (32)
  ) dut (
    .CLK                   (CLK),
    .RST_IN                (RST_IN),
    .M_AXIS_RC_TVALID      (tvalid),
    .M_AXIS_RC_TREADY      (tready),
    .M_AXIS_RC_TLAST       (tlast),
    .M_AXIS_RC_TDATA       (tdata),
    .M_AXIS_RC_TKEEP       (tkeep),
    .M_AXIS_RC_TUSER       (tuser),
    .RXC_DATA_READY        (rxready),
    .RXC_DATA_VALID        (rxvalid),
    .RXC_DATA              (rxdata),
    .RXC_DATA_START_FLAG   (rxsf),
    .RXC_DATA_START_OFFSET (rxso),
    .RXC_DATA_END_FLAG     (rxef),
    .RXC_DATA_END_OFFSET   (rxeo),
    .RXC_DATA_ERROR        (rxerr)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Output monitor: records accepted beats, checks hold-stability when stalled.
  logic          stall_prev = 1'b0;
  logic [DW-1:0] prev_d;
  logic [6:0]    prev_f;
  always @(negedge CLK) begin
    if (RST_IN) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        assert (rxvalid === 1'b1 && rxdata === prev_d &&
                {rxsf, rxso, rxef, rxeo, rxerr} === prev_f)
        else begin
          errors++;
          $error("FAIL stall_hold observed=%0b/%0h expected=1/%0h", rxvalid, rxdata, prev_d);
        end
      end
      if (rxvalid && rxready)
        outq.push_back('{rxdata, rxsf, rxso, rxef, rxeo, rxerr, cyc});
      stall_prev = rxvalid && !rxready;
      prev_d     = rxdata;
      prev_f     = {rxsf, rxso, rxef, rxeo, rxerr};
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present one beat at a negedge, wait for TREADY, return at the next negedge.
  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k,
                      input logic l, input logic sof, input logic disc);
    int n = 0;
    tvalid    = 1'b1;
    tdata     = d;
    tkeep     = k;
    tlast     = l;
    tuser     = '0;
    tuser[32] = sof;
    tuser[42] = disc;
    while (tready !== 1'b1 && n < 1000) begin
      @(negedge CLK);
      n++;
    end
    chk("send_tready", 128'(tready), 128'(1));
    last_acc = cyc;
    @(posedge CLK);
    @(negedge CLK);
    tvalid = 1'b0;
  endtask

  task automatic wait_out(input int n, input string tag);
    int t = 0;
    while (outq.size() < n && t < 3000) begin
      @(negedge CLK);
      t++;
    end
    repeat (4) @(negedge CLK);
    chk({tag, "_count"}, 128'(outq.size()), 128'(n));
  endtask

  task automatic chk_beat(input int idx, input string tag, input logic [DW-1:0] d,
                          input logic sf, input logic ef, input logic [OW-1:0] eo,
                          input logic err);
    chk($sformatf("%s_b%0d_present", tag, idx), 128'(outq.size() > idx), 128'(1));
    if (outq.size() > idx) begin
      chk($sformatf("%s_b%0d_data", tag, idx), outq[idx].d, d);
      chk($sformatf("%s_b%0d_sf", tag, idx), 128'(outq[idx].sf), 128'(sf));
      chk($sformatf("%s_b%0d_so", tag, idx), 128'(outq[idx].so), 128'(0));
      chk($sformatf("%s_b%0d_ef", tag, idx), 128'(outq[idx].ef), 128'(ef));
      chk($sformatf("%s_b%0d_eo", tag, idx), 128'(outq[idx].eo), 128'(eo));
      chk($sformatf("%s_b%0d_err", tag, idx), 128'(outq[idx].err), 128'(err));
    end
  endtask

  initial begin
    int acc0;
    int n_end;
    logic t0;

    // Reset state
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    chk("rst_tready", 128'(tready), 128'(0));
    chk("rst_outputs", 128'({rxvalid, rxsf, rxso, rxef, rxeo, rxerr}), 128'(0));
    chk("rst_data", rxdata, 128'(0));
    RST_IN = 1'b0;
    #1;
    chk("post_rst_tready", 128'(tready), 128'(0));
    chk("post_rst_valid", 128'(rxvalid), 128'(0));
    @(negedge CLK);
    chk("ready_after_rst", 128'(tready), 128'(1));

    // 3-beat packet, keep F,F,3
    outq.delete();
    send({4{32'h1111_0000}}, 4'hF, 1'b0, 1'b1, 1'b0);
    acc0 = last_acc;
    send({4{32'h1111_0001}}, 4'hF, 1'b0, 1'b0, 1'b0);
    send({4{32'h1111_0002}}, 4'h3, 1'b1, 1'b0, 1'b0);
    wait_out(3, "t1");
    chk_beat(0, "t1", {4{32'h1111_0000}}, 1'b1, 1'b0, 2'd0, 1'b0);
    chk_beat(1, "t1", {4{32'h1111_0001}}, 1'b0, 1'b0, 2'd0, 1'b0);
    chk_beat(2, "t1", {4{32'h1111_0002}}, 1'b0, 1'b1, 2'd1, 1'b0);
    if (outq.size() > 0)
      chk("t1_latency", 128'(outq[0].cyc - acc0), 128'(2));

    // 10 back-to-back single-beat packets
    outq.delete();
    for (int i = 0; i < 10; i++)
      send(128'(i + 100), 4'hF, 1'b1, 1'b1, 1'b0);
    wait_out(10, "t2");
    for (int i = 0; i < 10; i++) begin
      chk_beat(i, "t2", 128'(i + 100), 1'b1, 1'b1, 2'd3, 1'b0);
      if (i > 0 && outq.size() > i)
        chk($sformatf("t2_nobubble_%0d", i), 128'(outq[i].cyc - outq[i-1].cyc), 128'(1));
    end

    // 200 beats (4-beat packets) with random downstream READY
    outq.delete();
    rand_done = 1'b0;
    fork
      begin
        int t = 0;
        for (int i = 0; i < 200; i++)
          send({4{32'(i)}}, 4'hF, (i % 4) == 3, (i % 4) == 0, 1'b0);
        while (outq.size() < 200 && t < 5000) begin
          @(negedge CLK);
          t++;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge CLK);
          #1;
          t0 = tready;
          rxready = 1'($urandom_range(0, 1));
          #1;
          chk("tready_indep", 128'(tready), 128'(t0));
        end
      end
    join
    rxready = 1'b1;
    wait_out(200, "t3");
    for (int i = 0; i < 200; i++)
      chk_beat(i, "t3", {4{32'(i)}}, (i % 4) == 0, (i % 4) == 3,
               ((i % 4) == 3) ? 2'd3 : 2'd0, 1'b0);

    // Discontinue on middle beat, then a clean packet
    outq.delete();
    send({4{32'h4444_0000}}, 4'hF, 1'b0, 1'b1, 1'b0);
    send({4{32'h4444_0001}}, 4'hF, 1'b0, 1'b0, 1'b1);
    send({4{32'h4444_0002}}, 4'hF, 1'b1, 1'b0, 1'b0);
    send({4{32'h4444_0003}}, 4'hF, 1'b0, 1'b1, 1'b0);
    send({4{32'h4444_0004}}, 4'h7, 1'b1, 1'b0, 1'b0);
    wait_out(5, "t4");
    chk_beat(0, "t4", {4{32'h4444_0000}}, 1'b1, 1'b0, 2'd0, 1'b0);
    chk_beat(1, "t4", {4{32'h4444_0001}}, 1'b0, 1'b0, 2'd0, 1'b0);
    chk_beat(2, "t4", {4{32'h4444_0002}}, 1'b0, 1'b1, 2'd3, 1'b1);
    chk_beat(3, "t4", {4{32'h4444_0003}}, 1'b1, 1'b0, 2'd0, 1'b0);
    chk_beat(4, "t4", {4{32'h4444_0004}}, 1'b0, 1'b1, 2'd2, 1'b0);

    // Missing is_sof; non-contiguous keep on end beat; then clean
    outq.delete();
    send({4{32'h5555_0000}}, 4'hF, 1'b1, 1'b0, 1'b0);
    send({4{32'h5555_0001}}, 4'h5, 1'b1, 1'b1, 1'b0);
    send({4{32'h5555_0002}}, 4'hF, 1'b1, 1'b1, 1'b0);
    wait_out(3, "t5");
    chk_beat(0, "t5", {4{32'h5555_0000}}, 1'b1, 1'b1, 2'd3, 1'b1);
    chk_beat(1, "t5", {4{32'h5555_0001}}, 1'b1, 1'b1, 2'd2, 1'b1);
    chk_beat(2, "t5", {4{32'h5555_0002}}, 1'b1, 1'b1, 2'd3, 1'b0);

    // Reset pulse after beat 1 of a 4-beat packet
    outq.delete();
    send({4{32'h6666_0000}}, 4'hF, 1'b0, 1'b1, 1'b0);
    send({4{32'h6666_0001}}, 4'hF, 1'b0, 1'b0, 1'b0);
    #1;
    RST_IN = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("t6_rst_tready", 128'(tready), 128'(0));
    chk("t6_rst_valid", 128'(rxvalid), 128'(0));
    RST_IN = 1'b0;
    repeat (4) @(negedge CLK);
    n_end = 0;
    foreach (outq[i]) if (outq[i].ef) n_end++;
    chk("t6_no_end_beat", 128'(n_end), 128'(0));
    outq.delete();
    send({4{32'h7777_0000}}, 4'hF, 1'b0, 1'b1, 1'b0);
    send({4{32'h7777_0001}}, 4'h1, 1'b1, 1'b0, 1'b0);
    wait_out(2, "t6");
    chk_beat(0, "t6", {4{32'h7777_0000}}, 1'b1, 1'b0, 2'd0, 1'b0);
    chk_beat(1, "t6", {4{32'h7777_0001}}, 1'b0, 1'b1, 2'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
